// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - program counter, instruction memory and IR with field decode
// Memory is read asynchronously so loadir captures pre-write contents on a shared edge.
module fetch_decode_unit #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              loadir,
   input  logic              loadpc,
   input  logic              msel,
   input  logic              mwrite,
   input  logic [1:0]        nsel,
   input  logic [DATA_W-1:0] c_addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] mdata,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [2:0]        opcode,
   output logic [1:0]        op,
   output logic [2:0]        reg_num,
   output logic [1:0]        shift,
   output logic [DATA_W-1:0] sximm5,
   output logic [DATA_W-1:0] sximm8
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] addr;
   logic [2:0]        rn;
   logic [2:0]        rd;
   logic [2:0]        rm;
   logic              unused_addr_bits;

   // Data addresses come from the datapath; upper bits are simply truncated.
   assign addr             = msel ? c_addr[ADDR_W-1:0] : pc;
   assign unused_addr_bits = ^c_addr[DATA_W-1:ADDR_W];
   assign mdata            = mem[addr];

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= PC_INIT;
         ir <= '0;
      end else begin
         if (loadir) ir <= mdata;
         if (loadpc) pc <= pc + PC_ONE;
      end
   end

   // Memory has no reset; writes are suppressed only on reset edges.
   always_ff @(posedge clk) begin
      if (!reset && mwrite) mem[addr] <= wdata;
   end

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign shift  = ir[4:3];
   assign rm     = ir[2:0];
   assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
   assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

   always_comb begin
      reg_num = 3'b000;
      case (nsel)
         2'b00:   reg_num = rn;
         2'b01:   reg_num = rd;
         2'b10:   reg_num = rm;
         default: reg_num = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - directed self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        loadir;
   logic        loadpc;
   logic        msel;
   logic        mwrite;
   logic [1:0]  nsel;
   logic [15:0] c_addr;
   logic [15:0] wdata;
   logic [15:0] mdata;
   logic [7:0]  pc;
   logic [15:0] ir;
   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [2:0]  reg_num;
   logic [1:0]  shift;
   logic [15:0] sximm5;
   logic [15:0] sximm8;

   int tests = 0;
   int fails = 0;

   fetch_decode_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .loadir(loadir), .loadpc(loadpc), .msel(msel),
      .mwrite(mwrite), .nsel(nsel), .c_addr(c_addr), .wdata(wdata), .mdata(mdata),
      .pc(pc), .ir(ir), .opcode(opcode), .op(op), .reg_num(reg_num), .shift(shift),
      .sximm5(sximm5), .sximm8(sximm8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; loadir = 1'b0; loadpc = 1'b0; mwrite = 1'b0; msel = 1'b0;
   endtask

   task automatic mem_write(input logic [15:0] a, input logic [15:0] d);
      idle(); msel = 1'b1; c_addr = a; wdata = d; mwrite = 1'b1;
      cyc();
      idle();
   endtask

   task automatic pc_step(input int n);
      idle(); loadpc = 1'b1;
      for (int i = 0; i < n; i++) cyc();
      idle();
   endtask

   initial begin
      idle(); nsel = 2'b00; c_addr = '0; wdata = '0;
      reset = 1'b1;
      cyc(); cyc();
      idle();
      check("init_pc", pc, 8'h00);
      check("init_ir", ir, 16'h0000);

      // data write through c_addr with truncated upper bits
      idle(); msel = 1'b1; c_addr = 16'h0105; wdata = 16'hD1A5; mwrite = 1'b1;
      cyc();
      mwrite = 1'b0;
      check("wr_mdata", mdata, 16'hD1A5);
      check("wr_pc_unchanged", pc, 8'h00);
      c_addr = 16'h0005;
      check("wr_mem5", mdata, 16'hD1A5);

      // put pc=0x37, ir=0xFFFF, then reset with strobes active
      mem_write(16'h0020, 16'hFFFF);
      idle(); msel = 1'b1; c_addr = 16'h0020; loadir = 1'b1;
      cyc(); idle();
      check("pre_ir", ir, 16'hFFFF);
      pc_step(8'h37);
      check("pre_pc", pc, 8'h37);
      reset = 1'b1; loadpc = 1'b1; loadir = 1'b1; mwrite = 1'b1;
      msel = 1'b1; c_addr = 16'h0005; wdata = 16'h0BAD;
      cyc(); idle();
      check("rst_pc", pc, 8'h00);
      check("rst_ir", ir, 16'h0000);
      check("rst_opcode", opcode, 3'b000);
      check("rst_op", op, 2'b00);
      check("rst_reg_num", reg_num, 3'b000);
      check("rst_sximm5", sximm5, 16'h0000);
      check("rst_sximm8", sximm8, 16'h0000);
      msel = 1'b1; c_addr = 16'h0005;
      check("rst_mem_kept", mdata, 16'hD1A5);

      // fetch/decode from pc=0
      mem_write(16'h0000, 16'hD123);
      idle(); nsel = 2'b00; loadir = 1'b1;
      cyc(); idle();
      check("fetch_ir", ir, 16'hD123);
      check("fetch_opcode", opcode, 3'b110);
      check("fetch_op", op, 2'b10);
      check("fetch_rn", reg_num, 3'd1);
      check("fetch_sximm8", sximm8, 16'h0023);
      check("fetch_pc_hold", pc, 8'h00);
      pc_step(1);
      check("fetch_pc_inc", pc, 8'h01);

      // loadir + loadpc on one edge: IR from old PC
      mem_write(16'h0001, 16'h4321);
      idle(); loadir = 1'b1; loadpc = 1'b1;
      cyc(); idle();
      check("ldir_ldpc_ir", ir, 16'h4321);
      check("ldir_ldpc_pc", pc, 8'h02);

      // field decode
      mem_write(16'h0030, 16'hA0B3);
      idle(); msel = 1'b1; c_addr = 16'h0030; loadir = 1'b1;
      cyc(); idle();
      check("dec_opcode", opcode, 3'b101);
      check("dec_op", op, 2'b00);
      check("dec_shift", shift, 2'b10);
      check("dec_sximm5", sximm5, 16'hFFF3);
      nsel = 2'b00; #1 check("dec_nsel00", reg_num, 3'd0);
      nsel = 2'b01; #1 check("dec_nsel01", reg_num, 3'd5);
      nsel = 2'b10; #1 check("dec_nsel10", reg_num, 3'd3);
      nsel = 2'b11; #1 check("dec_nsel11", reg_num, 3'd0);
      mem_write(16'h0031, 16'hD1F0);
      idle(); msel = 1'b1; c_addr = 16'h0031; loadir = 1'b1;
      cyc(); idle();
      check("dec_sximm8_neg", sximm8, 16'hFFF0);

      // PC wrap
      pc_step(8'hFF - 8'h02);
      check("wrap_pc_ff", pc, 8'hFF);
      pc_step(1);
      check("wrap_pc_00", pc, 8'h00);
      pc_step(8'hFE);
      check("wrap_pc_fe", pc, 8'hFE);
      pc_step(3);
      check("wrap_pc_held3", pc, 8'h01);

      // read-before-write on a shared edge
      mem_write(16'h0010, 16'h1111);
      idle(); msel = 1'b1; c_addr = 16'h0010; wdata = 16'h2222; mwrite = 1'b1; loadir = 1'b1;
      cyc(); idle(); msel = 1'b1;
      check("rbw_ir", ir, 16'h1111);
      check("rbw_mdata", mdata, 16'h2222);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Memory-side counterpart of the datapath controller FSM: holds the program counter, instruction memory/RAM and instruction register.
- Executes the controller's loadir/loadpc/msel/mwrite strobes.
- Decodes the IR into the opcode/op fields the controller consumes, plus register numbers and sign-extended immediates for the datapath.
- Sits between the controller, the RAM image and the register file/datapath.

Parameters:
ADDR_W, 8, memory address width; memory depth = 2^ADDR_W words
DATA_W, 16, instruction/data word width (field map below fixed for 16)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
loadir  input  1  load IR from current memory read data
loadpc  input  1  increment PC
msel  input  1  address select: 0 = PC, 1 = c_addr
mwrite  input  1  write wdata to memory at selected address
nsel  input  2  register-number select: 00 rn, 01 rd, 10 rm, 11 zero
c_addr  input  DATA_W  datapath C output; low ADDR_W bits used as data address
wdata  input  DATA_W  memory write data (datapath B path)
mdata  output  DATA_W  combinational read of mem[selected address]
pc  output  ADDR_W  current PC
ir  output  DATA_W  current instruction register
opcode  output  3  ir[15:13]
op  output  2  ir[12:11]
reg_num  output  3  register number chosen by nsel
shift  output  2  ir[4:3]
sximm5  output  DATA_W  sign-extended ir[4:0]
sximm8  output  DATA_W  sign-extended ir[7:0]

Behaviour:
- Address mux: addr = msel ? c_addr[ADDR_W-1:0] : pc. mdata = mem[addr], asynchronous read, same-cycle.
- Reset (sync, high, highest priority): pc <= RESET_PC; ir <= 0; loadir/loadpc/mwrite ignored that edge.
  - Memory contents are NOT cleared.
  - After reset: opcode=0, op=0, reg_num=0, sximm5=0, sximm8=0.
- loadir at posedge: ir <= mdata as sampled before the edge, i.e. pre-write contents.
- loadpc at posedge: pc <= pc + 1 mod 2^ADDR_W. Wraps 2^ADDR_W-1 -> 0 with no flag.
- mwrite at posedge: mem[addr] <= wdata.
- Simultaneous events:
  - mwrite + loadir to the same address: IR gets old data (read-before-write); memory gets new data.
  - loadir + loadpc: IR loads from the old PC; PC increments.
  - All strobes are independent; none blocks another.
- Decode (combinational from ir only):
  - rn = ir[10:8], rd = ir[7:5], rm = ir[2:0].
  - reg_num per nsel; nsel=11 gives 000.
- Latency: IR/PC changes visible one edge after the strobe. mdata and decode outputs follow addr/ir combinationally.
- Controller contract:
  - loadir with msel=0 fetches the instruction; loadpc in the next state advances the PC.
  - LDR/STR use msel=1 with address from c_addr.
  - Strobes are level-sampled each edge. A strobe held N cycles acts N times; e.g. loadpc held 3 cycles gives pc+3.
- Out-of-range c_addr upper bits are ignored (truncation), never an error.
- X on any strobe while reset=1 does not propagate into pc/ir.

Test Plan:
- Reset: pc=0x37, ir=0xFFFF, assert reset 1 cycle with loadpc=1 -> pc=0x00, ir=0x0000, opcode=000; previously written mem[5]=0xD1A5 still reads 0xD1A5 with msel=1, c_addr=5.
- Data write/read: msel=1, c_addr=0x0105, wdata=0xD1A5, mwrite 1 cycle -> mem[0x05]=0xD1A5; mdata=0xD1A5 same cycle after the edge; pc unchanged.
- Fetch/decode: mem[0]=0xD123, pc=0, loadir -> ir=0xD123, opcode=110, op=10, reg_num(nsel=00)=1, sximm8=0x0023. Then loadpc -> pc=1.
- Field decode: IR loads 0xA0B3 -> opcode=101, op=00, shift=10, sximm5=0xFFF3. reg_num: nsel=00 -> 0, 01 -> 5, 10 -> 3, 11 -> 0. IR 0xD1F0 -> sximm8=0xFFF0.
- PC wrap: pc=0xFF, loadpc -> pc=0x00. loadpc held 3 cycles from 0xFE -> 0x01.
- Read-before-write: mem[0x10]=0x1111, msel=1, c_addr=0x10, wdata=0x2222, mwrite=1 and loadir=1 same edge -> ir=0x1111, mem[0x10]=0x2222, mdata=0x2222 afterwards.
